// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage 16-bit pipeline. Owns the program
// counter, picks the next PC (sequential / branch / call / return), drives
// the instruction-memory address and presents {instruction, PC+1} to the
// IF/ID pipeline register. On a HLT word it lets the HLT itself through,
// drains the pipe with NO_OP words for DRAIN_CYCLES cycles and then freezes
// fetch until reset.
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   DRAIN_CYCLES  NO_OP cycles issued after HLT before HALTED (1..7)
//   NO_OP         instruction word injected on squash / drain / halt
//   HLT           halt encoding
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst             asynchronous active-high reset
//   data_hazard     hold the PC and re-present the current word
//   branch_taken    taken branch resolved downstream (highest priority)
//   branch_target   absolute branch target
//   ret             return resolved downstream
//   ret_target      return address
//   call            call decoded in ID
//   call_target     call target, low 12 bits of the new PC
//   imem_data       instruction memory read data (combinational on imem_addr)
//   imem_addr       instruction memory address, equals the PC register
//   instruction_out instruction word to IF/ID
//   PC_out          PC+1 (word addressed, wraps) to IF/ID
//   halted          high while in HALTED
//   fetch_count     instructions accepted into IF/ID, wraps at 16 bits
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] NO_OP        = 16'hF000,
  parameter logic [15:0] HLT          = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_hazard,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        ret,
  input  logic [15:0] ret_target,
  input  logic        call,
  input  logic [11:0] call_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] instruction_out,
  output logic [15:0] PC_out,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Last value of the drain counter before HALTED is entered; the counter
  // runs 0..DRAIN_LAST, giving exactly DRAIN_CYCLES NO_OP cycles.
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [2:0]  drain_cnt_q;
  logic [2:0]  drain_cnt_d;
  logic [15:0] fetch_count_q;

  logic [15:0] pc_plus_one;
  logic        squash;
  logic        fetch_accept;

  assign pc_plus_one = pc_q + 16'd1;

  // Any redirect resolved this cycle makes the word currently being fetched
  // belong to the wrong path, so it is replaced by a NO_OP.
  assign squash = branch_taken | ret | call;

  // Output mux: outside RUN, or on a redirect, IF/ID only ever sees NO_OP.
  always_comb begin
    instruction_out = imem_data;
    if ((state_q != RUN) || squash) begin
      instruction_out = NO_OP;
    end
  end

  assign imem_addr   = pc_q;
  assign PC_out      = pc_plus_one;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

  // An instruction is accepted into IF/ID when we are running, not stalled
  // and not presenting a NO_OP. The HLT word itself is a real instruction
  // and therefore counts.
  assign fetch_accept = (state_q == RUN) && !data_hazard &&
                        (instruction_out != NO_OP);

  // State register: PC, FSM state and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Accepted-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (fetch_accept) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  // Next-state / next-PC logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (ret) begin
          pc_d = ret_target;
        end else if (call) begin
          // Calls stay inside the current 4K page.
          pc_d = {pc_q[15:12], call_target};
        end else if (data_hazard) begin
          pc_d = pc_q;
        end else if (imem_data == HLT) begin
          // PC parks on the HLT word; it is never advanced past it.
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          pc_d = pc_plus_one;
        end
      end

      DRAIN: begin
        // Older instructions still in flight may redirect, which means the
        // HLT was on a wrong path: resume fetching at the target. A call
        // can only come from the squashed slot behind the HLT, so it is
        // ignored here.
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = RUN;
        end else if (ret) begin
          pc_d    = ret_target;
          state_d = RUN;
        end else if (!data_hazard) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 3'd1;
          end
        end
      end

      HALTED: begin
        // Frozen until reset.
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. Directed scenario tasks check
// against constants; the randomized task checks against a behavioural
// model of the fetch stage (PC, mode and remaining-drain countdown).
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [15:0] NOP_W = 16'hF000;
  localparam logic [15:0] HLT_W = 16'hFFFF;
  localparam int          DRAIN = 3;

  logic        clk;
  logic        rst;
  logic        data_hazard;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        ret;
  logic [15:0] ret_target;
  logic        call;
  logic [11:0] call_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] instruction_out;
  logic [15:0] PC_out;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:65535];

  int checks;
  int errors;

  if_fetch_stage #(
    .RESET_PC    (16'h0000),
    .DRAIN_CYCLES(DRAIN),
    .NO_OP       (NOP_W),
    .HLT         (HLT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_hazard    (data_hazard),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .ret            (ret),
    .ret_target     (ret_target),
    .call           (call),
    .call_target    (call_target),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .instruction_out(instruction_out),
    .PC_out         (PC_out),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory.
  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    data_hazard   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    ret           = 1'b0;
    ret_target    = 16'h0000;
    call          = 1'b0;
    call_target   = 12'h000;
  endtask

  task automatic fill_mem(input logic [15:0] word);
    for (int i = 0; i < 65536; i++) mem[i] = word;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset without checks; leaves us at a negedge with rst released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    fill_mem(16'h1234);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_addr got %h want %h", imem_addr, 16'h0000);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_halted got %b want 0", halted);
    end
    checks++;
    if (fetch_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_fcount got %h want 0000", fetch_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (imem_addr !== 16'(i)) begin
        errors++;
        $display("[TB] FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 16'(i));
      end
      checks++;
      if (PC_out !== 16'(i + 1)) begin
        errors++;
        $display("[TB] FAIL seq_pcout[%0d] got %h want %h", i, PC_out, 16'(i + 1));
      end
      checks++;
      if (instruction_out !== 16'h1234) begin
        errors++;
        $display("[TB] FAIL seq_instr[%0d] got %h want 1234", i, instruction_out);
      end
      tick();
    end
    checks++;
    if (fetch_count !== 16'd4) begin
      errors++;
      $display("[TB] FAIL seq_fcount got %0d want 4", fetch_count);
    end
  endtask

  task automatic test_hazard();
    mem[5] = 16'h5A5A;
    tick();                      // PC 4 -> 5
    data_hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (imem_addr !== 16'h0005) begin
        errors++;
        $display("[TB] FAIL hz_addr[%0d] got %h want 0005", i, imem_addr);
      end
      checks++;
      if (instruction_out !== 16'h5A5A) begin
        errors++;
        $display("[TB] FAIL hz_instr[%0d] got %h want 5a5a", i, instruction_out);
      end
      checks++;
      if (fetch_count !== 16'd5) begin
        errors++;
        $display("[TB] FAIL hz_fcount[%0d] got %0d want 5", i, fetch_count);
      end
      tick();
    end
    data_hazard = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 16'h0005 || fetch_count !== 16'd5) begin
      errors++;
      $display("[TB] FAIL hz_after addr %h fc %0d want 0005 5", imem_addr, fetch_count);
    end
    tick();
    checks++;
    if (imem_addr !== 16'h0006 || fetch_count !== 16'd6) begin
      errors++;
      $display("[TB] FAIL hz_resume addr %h fc %0d want 0006 6", imem_addr, fetch_count);
    end
  endtask

  task automatic test_call();
    branch_taken  = 1'b1;
    branch_target = 16'h3010;
    tick();
    branch_taken  = 1'b0;
    call          = 1'b1;
    call_target   = 12'h0AB;
    #1;
    checks++;
    if (imem_addr !== 16'h3010) begin
      errors++;
      $display("[TB] FAIL call_pre_addr got %h want 3010", imem_addr);
    end
    checks++;
    if (instruction_out !== NOP_W) begin
      errors++;
      $display("[TB] FAIL call_squash got %h want f000", instruction_out);
    end
    tick();
    call = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 16'h30AB) begin
      errors++;
      $display("[TB] FAIL call_addr got %h want 30ab", imem_addr);
    end
    checks++;
    if (fetch_count !== 16'd6) begin
      errors++;
      $display("[TB] FAIL call_fcount got %0d want 6", fetch_count);
    end
  endtask

  task automatic test_branch_call();
    branch_taken  = 1'b1;
    branch_target = 16'h0200;
    call          = 1'b1;
    call_target   = 12'h055;
    #1;
    checks++;
    if (instruction_out !== NOP_W) begin
      errors++;
      $display("[TB] FAIL brcall_squash got %h want f000", instruction_out);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (imem_addr !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL brcall_addr got %h want 0200", imem_addr);
    end
  endtask

  task automatic test_halt();
    mem[7]        = HLT_W;
    branch_taken  = 1'b1;
    branch_target = 16'h0007;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (imem_addr !== 16'h0007 || instruction_out !== HLT_W || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hlt_pass addr %h instr %h halted %b want 0007 ffff 0",
               imem_addr, instruction_out, halted);
    end
    tick();
    for (int i = 0; i < DRAIN; i++) begin
      #1;
      checks++;
      if (imem_addr !== 16'h0007 || instruction_out !== NOP_W || halted !== 1'b0) begin
        errors++;
        $display("[TB] FAIL drain[%0d] addr %h instr %h halted %b want 0007 f000 0",
                 i, imem_addr, instruction_out, halted);
      end
      tick();
    end
    checks++;
    if (halted !== 1'b1 || imem_addr !== 16'h0007 || instruction_out !== NOP_W) begin
      errors++;
      $display("[TB] FAIL halted_state halted %b addr %h instr %h want 1 0007 f000",
               halted, imem_addr, instruction_out);
    end
    checks++;
    if (fetch_count !== 16'd7) begin
      errors++;
      $display("[TB] FAIL halt_fcount got %0d want 7", fetch_count);
    end
    branch_taken  = 1'b1;
    branch_target = 16'h1111;
    ret           = 1'b1;
    ret_target    = 16'h2222;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (halted !== 1'b1 || imem_addr !== 16'h0007) begin
      errors++;
      $display("[TB] FAIL halt_ignore halted %b addr %h want 1 0007", halted, imem_addr);
    end
  endtask

  task automatic test_drain_cancel();
    fill_mem(16'h1234);
    mem[16'h0020] = HLT_W;
    clear_inputs();
    do_reset();
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (instruction_out !== HLT_W) begin
      errors++;
      $display("[TB] FAIL cancel_hlt got %h want ffff", instruction_out);
    end
    tick();                      // now in the first DRAIN cycle
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (imem_addr !== 16'h0040 || halted !== 1'b0 || instruction_out !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL cancel_resume addr %h halted %b instr %h want 0040 0 1234",
               imem_addr, halted, instruction_out);
    end
    checks++;
    if (fetch_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL cancel_fcount got %0d want 1", fetch_count);
    end
    tick();
    checks++;
    if (imem_addr !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL cancel_run addr %h want 0041", imem_addr);
    end
    // Halt again, then reset mid-HALTED.
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    tick();
    clear_inputs();
    for (int i = 0; i < DRAIN + 3; i++) tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rehalt got %b want 1", halted);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 16'h0000 || halted !== 1'b0 || fetch_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_rst addr %h halted %b fc %h want 0000 0 0000",
               imem_addr, halted, fetch_count);
    end
    #2;
    rst = 1'b0;
  endtask

  // Randomized run against a behavioural model: the model keeps the PC, a
  // mode (running / draining / halted) and a count of drain slots left.
  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_fc;
    int          m_mode;         // 0 running, 1 draining, 2 halted
    int          m_left;
    int          halt_wait;
    logic [15:0] word;
    logic [15:0] exp_out;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = ($urandom_range(0, 39) == 0) ? HLT_W : 16'($urandom);
    end
    clear_inputs();
    do_reset();
    m_pc = 16'h0000; m_fc = 16'h0000; m_mode = 0; m_left = 0; halt_wait = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (m_mode == 2) halt_wait++;
      if (halt_wait > 4) begin
        clear_inputs();
        do_reset();
        m_pc = 16'h0000; m_fc = 16'h0000; m_mode = 0; m_left = 0; halt_wait = 0;
      end
      data_hazard   = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      ret           = ($urandom_range(0, 11) == 0);
      ret_target    = 16'($urandom);
      call          = ($urandom_range(0, 9) == 0);
      call_target   = 12'($urandom);
      #1;

      word    = mem[m_pc];
      exp_out = (m_mode != 0 || branch_taken || ret || call) ? NOP_W : word;

      checks++;
      if (imem_addr !== m_pc || PC_out !== m_pc + 16'd1) begin
        errors++;
        $display("[TB] FAIL rnd_pc[%0d] addr %h pcout %h want %h %h",
                 cyc, imem_addr, PC_out, m_pc, m_pc + 16'd1);
      end
      checks++;
      if (instruction_out !== exp_out) begin
        errors++;
        $display("[TB] FAIL rnd_instr[%0d] got %h want %h", cyc, instruction_out, exp_out);
      end
      checks++;
      if (halted !== (m_mode == 2) || fetch_count !== m_fc) begin
        errors++;
        $display("[TB] FAIL rnd_status[%0d] halted %b fc %h want %b %h",
                 cyc, halted, fetch_count, (m_mode == 2), m_fc);
      end

      @(posedge clk);
      if (m_mode == 0) begin
        if (!data_hazard && exp_out != NOP_W) m_fc = m_fc + 16'd1;
        if (branch_taken)      m_pc = branch_target;
        else if (ret)          m_pc = ret_target;
        else if (call)         m_pc = {m_pc[15:12], call_target};
        else if (!data_hazard) begin
          if (word == HLT_W) begin
            m_mode = 1;
            m_left = DRAIN;
          end else begin
            m_pc = m_pc + 16'd1;
          end
        end
      end else if (m_mode == 1) begin
        if (branch_taken) begin
          m_pc = branch_target; m_mode = 0;
        end else if (ret) begin
          m_pc = ret_target; m_mode = 0;
        end else if (!data_hazard) begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    fill_mem(16'h1234);
    test_reset();
    test_sequential();
    test_hazard();
    test_call();
    test_branch_call();
    test_halt();
    test_drain_cancel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter, selects next PC (sequential / branch / call / return), drives the instruction-memory address, and presents {instruction, PC+1} to IF/ID.
- Honours data-hazard stalls and detects HLT, draining the pipe before freezing fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DRAIN_CYCLES, 3, NO_OP cycles issued after HLT before entering HALTED; legal range 1..7.
- NO_OP, 16'hF000, instruction word injected on squash/drain/halt.
- HLT, 16'hFFFF, halt encoding.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- data_hazard  input  1  hold PC; instruction_out re-presents the current word.
- branch_taken  input  1  taken branch resolved downstream.
- branch_target  input  16  absolute branch target.
- ret  input  1  return resolved downstream.
- ret_target  input  16  return address.
- call  input  1  call decoded in ID.
- call_target  input  12  call target, Inst[11:0].
- imem_data  input  16  instruction memory read data; combinational read of imem_addr.
- imem_addr  output  16  equals PC register.
- instruction_out  output  16  to IF/ID instruction_in.
- PC_out  output  16  PC+1 (word addressed), to IF/ID PC_in.
- halted  output  1  high in HALTED state.
- fetch_count  output  16  count of instructions accepted into IF/ID.

Behaviour:
- Reset, async: PC=RESET_PC, state=RUN, drain counter=0, halted=0, fetch_count=0. Reset mid-DRAIN or mid-HALTED returns to RUN at RESET_PC.
- States: RUN, DRAIN, HALTED.
- Next-PC priority, evaluated each posedge in RUN/DRAIN:
  1. branch_taken: PC <= branch_target.
  2. ret: PC <= ret_target.
  3. call: PC <= {PC[15:12], call_target}.
  4. data_hazard: PC holds.
  5. Otherwise in RUN: PC <= PC+1, 16-bit wrap (FFFF -> 0000).
- Output mux (combinational):
  - instruction_out = NO_OP if state != RUN, or branch_taken, or ret, or call.
  - Otherwise instruction_out = imem_data.
  - PC_out = PC+1 always (wraps).
- HLT detection: in RUN, imem_data==HLT with no redirect and no data_hazard:
  - HLT word itself passes to instruction_out.
  - PC is not incremented.
  - State -> DRAIN, counter=0.
- DRAIN:
  - NO_OP emitted; counter increments each cycle.
  - When counter == DRAIN_CYCLES-1: state -> HALTED.
  - A branch_taken or ret in DRAIN (an older instruction redirecting) cancels the halt: PC <= target, state -> RUN.
  - call is ignored in DRAIN.
  - data_hazard freezes the counter.
- HALTED: PC frozen, NO_OP emitted, halted=1, all redirects ignored; exit only via rst.
- fetch_count: +1 on each posedge where state==RUN, no data_hazard, and instruction_out != NO_OP (HLT counts). Wraps at 16 bits.
- Simultaneous branch_taken and call: branch wins; the call instruction is squashed.

Test Plan:
- Reset to RESET_PC=0, imem returns 16'h1234 at every address, run 4 cycles -> imem_addr 0,1,2,3; PC_out 1,2,3,4; fetch_count=4.
- data_hazard high for 2 cycles at PC=5 -> imem_addr holds at 5; instruction_out = imem[5] repeated; fetch_count does not advance.
- At PC=0x3010, call with call_target=0x0AB -> next imem_addr=0x30AB; instruction_out=F000 during the call cycle.
- branch_taken with target 0x0200 together with call (target 0x055) -> imem_addr=0x0200 next cycle.
- HLT at PC=7, DRAIN_CYCLES=3 -> HLT output once, then F000 for 3 cycles, then halted=1; imem_addr stays 7 thereafter; a later branch_taken is ignored.
- HLT fetched, branch_taken target 0x40 in first DRAIN cycle -> state RUN, imem_addr=0x40, halted stays 0; assert rst mid-HALTED -> imem_addr=RESET_PC, halted=0 immediately.
